// File: rtl/usb_tx_core.sv
// USB full-speed transmitter for ACK/NAK handshakes and DATA0 packets: NRZI, bit stuffing, EOP.
// Define USB_TX_CRC_EN to append the CRC16 field to DATA0 packets.
module usb_tx_core (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tx_packet,
  input  logic [6:0] tx_packet_size,
  input  logic [7:0] tx_packet_data,
  input  logic       hresp,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_transfer_active,
  output logic       tx_error,
  output logic       get_tx_packet_data
);
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP} state_t;

  localparam logic [1:0] CMD_DATA0 = 2'b01;
  localparam logic [1:0] CMD_NAK   = 2'b10;
  localparam logic [1:0] CMD_ACK   = 2'b11;
  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // r_state/r_idx/r_stuff describe the bit currently shown on the line
  state_t     r_state, w_state_next;
  logic [2:0] r_idx, w_idx_next;
  logic       r_stuff, w_stuff_next;
  logic [2:0] r_ones, w_ones_next;
  logic [7:0] r_byte, w_byte_next;
  logic       w_bit_next;
  logic [1:0] r_cmd, w_cmd_next;
  logic [6:0] r_left, w_left_next;
  logic [1:0] r_eop_cnt, w_eop_cnt_next;
  logic [7:0] r_buf;
  logic [7:0] w_fetched;
  logic       w_size_err, w_abort;
  logic       w_dplus_next, w_dminus_next, w_active_next, w_error_next, w_get_next;
`ifdef USB_TX_CRC_EN
  logic        r_bit;
  logic        r_crc_hi, w_crc_hi_next;
  logic [15:0] r_crc, w_crc_step, w_crc_next;
`endif

  function automatic logic [7:0] pid_for(input logic [1:0] cmd);
    case (cmd)
      CMD_ACK: return 8'hD2;
      CMD_NAK: return 8'h5A;
      default: return 8'hC3;
    endcase
  endfunction

  // The fetched byte may be consumed on the strobe edge itself or after a stuffed bit
  assign w_fetched  = get_tx_packet_data ? tx_packet_data : r_buf;
  assign w_size_err = (r_state == S_IDLE) && (tx_packet == CMD_DATA0) && (tx_packet_size > 7'd64);
  assign w_abort    = (r_state == S_DATA) && hresp;

`ifdef USB_TX_CRC_EN
  // Reflected form of polynomial 0x8005, fed with payload bits in line order
  always_comb begin
    w_crc_step = r_crc;
    if (r_state == S_DATA && !r_stuff)
      w_crc_step = (r_crc[0] ^ r_bit) ? ((r_crc >> 1) ^ 16'hA001) : (r_crc >> 1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= S_IDLE;
      r_idx              <= 3'd0;
      r_stuff            <= 1'b0;
      r_ones             <= 3'd0;
      r_byte             <= 8'd0;
      r_cmd              <= 2'b00;
      r_left             <= 7'd0;
      r_eop_cnt          <= 2'd0;
      r_buf              <= 8'd0;
      dplus_out          <= 1'b1;
      dminus_out         <= 1'b0;
      tx_transfer_active <= 1'b0;
      tx_error           <= 1'b0;
      get_tx_packet_data <= 1'b0;
`ifdef USB_TX_CRC_EN
      r_bit              <= 1'b0;
      r_crc_hi           <= 1'b0;
      r_crc              <= 16'hFFFF;
`endif
    end else begin
      r_state            <= w_state_next;
      r_idx              <= w_idx_next;
      r_stuff            <= w_stuff_next;
      r_ones             <= w_ones_next;
      r_byte             <= w_byte_next;
      r_cmd              <= w_cmd_next;
      r_left             <= w_left_next;
      r_eop_cnt          <= w_eop_cnt_next;
      if (get_tx_packet_data)
        r_buf <= tx_packet_data;
      dplus_out          <= w_dplus_next;
      dminus_out         <= w_dminus_next;
      tx_transfer_active <= w_active_next;
      tx_error           <= w_error_next;
      get_tx_packet_data <= w_get_next;
`ifdef USB_TX_CRC_EN
      r_bit              <= w_bit_next;
      r_crc_hi           <= w_crc_hi_next;
      r_crc              <= w_crc_next;
`endif
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_stuff_next   = 1'b0;
    w_ones_next    = 3'd0;
    w_byte_next    = r_byte;
    w_bit_next     = 1'b1;
    w_cmd_next     = r_cmd;
    w_left_next    = r_left;
    w_eop_cnt_next = 2'd0;
`ifdef USB_TX_CRC_EN
    w_crc_hi_next  = r_crc_hi;
    w_crc_next     = w_crc_step;
`endif
    case (r_state)
      S_IDLE: begin
        if (tx_packet != 2'b00 && !w_size_err) begin
          w_state_next = S_SYNC;
          w_idx_next   = 3'd0;
          w_byte_next  = SYNC_BYTE;
          w_bit_next   = SYNC_BYTE[0];
          w_cmd_next   = tx_packet;
          w_left_next  = (tx_packet == CMD_DATA0) ? tx_packet_size : 7'd0;
`ifdef USB_TX_CRC_EN
          w_crc_next   = 16'hFFFF;
`endif
        end
      end
      S_EOP: begin
        if (r_eop_cnt == 2'd2)
          w_state_next = S_IDLE;
        else
          w_eop_cnt_next = r_eop_cnt + 2'd1;
      end
      default: begin
        if (w_abort) begin
          w_state_next = S_EOP;
        end else if (r_ones == 3'd6) begin
          w_stuff_next = 1'b1;
          w_bit_next   = 1'b0;
        end else if (r_idx != 3'd7) begin
          w_idx_next = r_idx + 3'd1;
          w_bit_next = r_byte[w_idx_next];
        end else begin
          w_idx_next = 3'd0;
          case (r_state)
            S_SYNC: begin
              w_state_next = S_PID;
              w_byte_next  = pid_for(r_cmd);
            end
            S_PID, S_DATA: begin
              if (r_cmd != CMD_DATA0) begin
                w_state_next = S_EOP;
              end else if (r_left != 7'd0) begin
                w_state_next = S_DATA;
                w_byte_next  = w_fetched;
                w_left_next  = r_left - 7'd1;
              end else begin
`ifdef USB_TX_CRC_EN
                w_state_next  = S_CRC;
                w_byte_next   = ~w_crc_step[7:0];
                w_crc_hi_next = 1'b0;
`else
                w_state_next  = S_EOP;
`endif
              end
            end
`ifdef USB_TX_CRC_EN
            S_CRC: begin
              if (!r_crc_hi) begin
                w_crc_hi_next = 1'b1;
                w_byte_next   = ~r_crc[15:8];
              end else begin
                w_state_next  = S_EOP;
              end
            end
`endif
            default: w_state_next = S_EOP;
          endcase
          w_bit_next = w_byte_next[0];
        end
        if (!w_stuff_next && w_bit_next &&
            (w_state_next == S_PID || w_state_next == S_DATA || w_state_next == S_CRC))
          w_ones_next = r_ones + 3'd1;
      end
    endcase
  end

  always_comb begin
    w_dplus_next  = 1'b1;
    w_dminus_next = 1'b0;
    case (w_state_next)
      S_IDLE: ;
      S_EOP: begin
        if (w_eop_cnt_next != 2'd2)
          w_dplus_next = 1'b0;
      end
      default: begin
        w_dplus_next  = w_bit_next ? dplus_out : ~dplus_out;
        w_dminus_next = ~w_dplus_next;
      end
    endcase
    w_active_next = (w_state_next != S_IDLE);
    w_error_next  = w_size_err || w_abort;
    // Strobe on the last real bit of the field that precedes each payload byte
    w_get_next    = (w_state_next == S_PID || w_state_next == S_DATA) && (w_idx_next == 3'd7) &&
                    !w_stuff_next && (w_left_next != 7'd0);
  end
endmodule

// File: tb/tb_usb_tx_core.sv
// Randomized bench for usb_tx_core: a packet-level model expands fields, stuffing, NRZI and EOP into per-cycle line values.
module tb_usb_tx_core;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] tx_packet;
  logic [6:0] tx_packet_size;
  logic [7:0] tx_packet_data;
  logic       hresp;
  logic       dplus_out, dminus_out, tx_transfer_active, tx_error, get_tx_packet_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] exp_q[$];     // {dplus, dminus, active, error, get} per cycle after the start edge
  int         abort_ok[$];  // cycles showing a non-final, unstuffed payload bit
  logic       rb[$];
  int         rf[$];
  logic       rg[$];
  int         ri[$];
  logic [7:0] pay[$];

  always #5 clk = ~clk;

  usb_tx_core dut (
    .clk                (clk),
    .rst                (rst),
    .tx_packet          (tx_packet),
    .tx_packet_size     (tx_packet_size),
    .tx_packet_data     (tx_packet_data),
    .hresp              (hresp),
    .dplus_out          (dplus_out),
    .dminus_out         (dminus_out),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error),
    .get_tx_packet_data (get_tx_packet_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

`ifdef USB_TX_CRC_EN
  function automatic logic [15:0] crc16_usb();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pay[i]) begin
      c = c ^ {8'h00, pay[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction
`endif

  task automatic push_field(input logic [7:0] v, input int fld, input logic strobe_last);
    for (int i = 0; i < 8; i++) begin
      rb.push_back(v[i]);
      rf.push_back(fld);
      rg.push_back(strobe_last && (i == 7));
      ri.push_back(i);
    end
  endtask

  task automatic build_model(input logic [1:0] cmd);
    logic [7:0] pid;
    logic       lvl;
    int         ones;
`ifdef USB_TX_CRC_EN
    logic [15:0] crc;
`endif
    rb.delete(); rf.delete(); rg.delete(); ri.delete();
    exp_q.delete(); abort_ok.delete();
    case (cmd)
      2'b11:   pid = 8'hD2;
      2'b10:   pid = 8'h5A;
      default: pid = 8'hC3;
    endcase
    push_field(8'h80, 0, 1'b0);
    push_field(pid, 1, (cmd == 2'b01) && (pay.size() > 0));
    if (cmd == 2'b01) begin
      foreach (pay[b]) push_field(pay[b], 2, b < pay.size() - 1);
`ifdef USB_TX_CRC_EN
      crc = crc16_usb();
      push_field(crc[7:0], 3, 1'b0);
      push_field(crc[15:8], 3, 1'b0);
`endif
    end
    lvl  = 1'b1;
    ones = 0;
    foreach (rb[i]) begin
      if (!rb[i]) lvl = ~lvl;
      exp_q.push_back({lvl, ~lvl, 1'b1, 1'b0, rg[i]});
      if (rf[i] == 2 && ri[i] < 7) abort_ok.push_back(exp_q.size());
      if (rf[i] != 0) begin
        ones = rb[i] ? ones + 1 : 0;
        if (ones == 6) begin
          lvl = ~lvl;
          exp_q.push_back({lvl, ~lvl, 1'b1, 1'b0, 1'b0});
          ones = 0;
        end
      end
    end
  endtask

  task automatic finish_model(input int abort_k);
    if (abort_k > 0)
      while (exp_q.size() > abort_k) void'(exp_q.pop_back());
    exp_q.push_back({2'b00, 1'b1, (abort_k > 0), 1'b0});
    exp_q.push_back(5'b00100);
    exp_q.push_back(5'b10100);
    exp_q.push_back(5'b10000);
  endtask

  task automatic run_txn(input string name, input logic [1:0] cmd, input int size, input int abort_k);
    int ptr;
    int errs0;
    ptr   = 0;
    errs0 = n_errors;
    @(negedge clk);
    tx_packet      = cmd;
    tx_packet_size = 7'(size);
    tx_packet_data = 8'($urandom);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      tx_packet = 2'b00;
      hresp     = (c == abort_k);
      chk($sformatf("%s cyc%0d", name, c),
          {dplus_out, dminus_out, tx_transfer_active, tx_error, get_tx_packet_data}, exp_q[c-1]);
      if (get_tx_packet_data) begin
        if (ptr < pay.size()) begin
          tx_packet_data = pay[ptr];
          ptr++;
        end else begin
          tx_packet_data = 8'($urandom);
        end
      end
    end
    hresp = 1'b0;
    $display("txn %s cmd=%0d size=%0d abort=%0d cycles=%0d errors=%0d",
             name, cmd, size, abort_k, exp_q.size(), n_errors - errs0);
  endtask

  task automatic data_txn(input string name, input int abort_sel);
    int k;
    build_model(2'b01);
    k = 0;
    if (abort_sel >= 0 && abort_ok.size() > 0)
      k = abort_ok[abort_sel % abort_ok.size()];
    finish_model(k);
    run_txn(name, 2'b01, pay.size(), k);
  endtask

  initial begin
    int n;
    rst = 1'b1; tx_packet = 2'b00; tx_packet_size = 7'd0; tx_packet_data = 8'd0; hresp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", {dplus_out, dminus_out, tx_transfer_active, tx_error, get_tx_packet_data}, 5'b10000);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i), {dplus_out, dminus_out, tx_transfer_active, tx_error, get_tx_packet_data}, 5'b10000);
    end

    pay.delete(); build_model(2'b10); finish_model(0); run_txn("nak", 2'b10, 0, 0);
    pay.delete(); build_model(2'b11); finish_model(0); run_txn("ack", 2'b11, 0, 0);
    pay = '{8'hF0, 8'h0F}; data_txn("d_f0_0f", -1);
    pay = '{8'hFF};        data_txn("d_ff", -1);
    pay.delete();          data_txn("d_empty", -1);

    exp_q = '{5'b10010, 5'b10000, 5'b10000};
    pay.delete();
    run_txn("size65", 2'b01, 65, 0);

    pay = '{8'h12, 8'hFF, 8'h34, 8'h56};
    data_txn("abort", 10);

    for (int t = 0; t < 30; t++) begin
      pay.delete();
      n = (t % 3 == 0) ? int'($urandom_range(0, 64)) : int'($urandom_range(0, 8));
      for (int b = 0; b < n; b++)
        pay.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      case ($urandom_range(0, 3))
        0: begin pay.delete(); build_model(2'b11); finish_model(0); run_txn("rnd_ack", 2'b11, 0, 0); end
        1: begin pay.delete(); build_model(2'b10); finish_model(0); run_txn("rnd_nak", 2'b10, 0, 0); end
        2: data_txn("rnd_abort", int'($urandom_range(0, 500)));
        default: data_txn("rnd_data", -1);
      endcase
    end

    // Reset in the middle of a packet abandons it without EOP
    @(negedge clk);
    tx_packet = 2'b01; tx_packet_size = 7'd3;
    @(negedge clk);
    tx_packet = 2'b00;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset", {dplus_out, dminus_out, tx_transfer_active, tx_error, get_tx_packet_data}, 5'b10000);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset", {dplus_out, dminus_out, tx_transfer_active, tx_error, get_tx_packet_data}, 5'b10000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
